// File: rtl/alu_pipe_hs.sv
// Registered eight-opcode ALU with valid/ready handshakes and a multi-cycle logical shift right.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_pipe_hs #(
  parameter int NUMBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] result,
  output logic               carryout,
  output logic               overflow,
  output logic               zero,
  output logic               busy
);

  localparam int SHW = $clog2(NUMBITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [NUMBITS-1:0] work, work_next;
  logic [SHW-1:0]     count, count_next;
  logic [NUMBITS-1:0] result_next;
  logic               carry_next, ovf_next, zero_next, valid_next;

  logic               accept;
  logic [SHW-1:0]     shamt;
  logic [NUMBITS:0]   sum_ext, diff_ext;
  logic [NUMBITS-1:0] alu_res;
  logic               alu_carry, alu_ovf;
`ifdef ALU_BARREL_SHIFT_EN
  logic [NUMBITS-1:0] pre_shift;
`endif

  assign shamt    = B[SHW-1:0];
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == SHIFT);

  // Single-cycle result for every opcode that completes on the accept edge.
  always_comb begin
    sum_ext   = {1'b0, A} + {1'b0, B};
    diff_ext  = {1'b0, A} - {1'b0, B};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
`ifdef ALU_BARREL_SHIFT_EN
    pre_shift = A >> (shamt - SHW'(1));
`endif
    case (opcode)
      3'd0: begin
        alu_res   = sum_ext[NUMBITS-1:0];
        alu_carry = sum_ext[NUMBITS];
      end
      3'd1: begin
        alu_res = sum_ext[NUMBITS-1:0];
        alu_ovf = (A[NUMBITS-1] == B[NUMBITS-1]) && (sum_ext[NUMBITS-1] != A[NUMBITS-1]);
      end
      3'd2: begin
        alu_res   = diff_ext[NUMBITS-1:0];
        alu_carry = diff_ext[NUMBITS];
      end
      3'd3: begin
        alu_res = diff_ext[NUMBITS-1:0];
        alu_ovf = (A[NUMBITS-1] != B[NUMBITS-1]) && (diff_ext[NUMBITS-1] != A[NUMBITS-1]);
      end
      3'd4: alu_res = A & B;
      3'd5: alu_res = A | B;
      3'd6: alu_res = A ^ B;
      default: begin
`ifdef ALU_BARREL_SHIFT_EN
        alu_res   = A >> shamt;
        alu_carry = (shamt != '0) ? pre_shift[0] : 1'b0;
`else
        // Only reached here for a zero shift amount; nonzero shifts go through SHIFT.
        alu_res   = A;
`endif
      end
    endcase
  end

  // Next-state and datapath updates; a new accept overrides the DONE drain.
  always_comb begin
    state_next  = state;
    work_next   = work;
    count_next  = count;
    result_next = result;
    carry_next  = carryout;
    ovf_next    = overflow;
    zero_next   = zero;
    valid_next  = out_valid;

    case (state)
      SHIFT: begin
        work_next  = work >> 1;
        count_next = count - SHW'(1);
        if (count == SHW'(1)) begin
          result_next = work >> 1;
          carry_next  = work[0];
          ovf_next    = 1'b0;
          zero_next   = ((work >> 1) == '0);
          valid_next  = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready && !accept) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      if (opcode == 3'd7) begin
        work_next  = A;
        count_next = shamt;
      end
      if ((opcode == 3'd7) && (shamt != '0)) begin
        valid_next = 1'b0;
        state_next = SHIFT;
      end else begin
`else
      begin
`endif
        result_next = alu_res;
        carry_next  = alu_carry;
        ovf_next    = alu_ovf;
        zero_next   = (alu_res == '0);
        valid_next  = 1'b1;
        state_next  = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      work      <= '0;
      count     <= '0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      work      <= work_next;
      count     <= count_next;
      result    <= result_next;
      carryout  <= carry_next;
      overflow  <= ovf_next;
      zero      <= zero_next;
      out_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Self-checking bench for alu_pipe_hs: directed corner cases, backpressure, async reset and
// randomized operations checked against an arithmetic reference model.
module tb_alu_pipe_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic [2:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carryout, overflow, zero, busy;

  int checks = 0;
  int errors = 0;

  alu_pipe_hs #(.NUMBITS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int to_signed16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic void model(input int op, input int a, input int b,
                                output int res, output int car, output int ovf, output int lat);
    int s, sh;
    res = 0; car = 0; ovf = 0; lat = 1;
    case (op)
      0: begin s = a + b; res = s % 65536; car = s / 65536; end
      1: begin
        res = (a + b) % 65536;
        s = to_signed16(a) + to_signed16(b);
        ovf = (s > 32767 || s < -32768) ? 1 : 0;
      end
      2: begin res = (a - b + 65536) % 65536; car = (a < b) ? 1 : 0; end
      3: begin
        res = (a - b + 65536) % 65536;
        s = to_signed16(a) - to_signed16(b);
        ovf = (s > 32767 || s < -32768) ? 1 : 0;
      end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      default: begin
        sh = b % 16;
        res = a >> sh;
        car = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1);
`ifndef ALU_BARREL_SHIFT_EN
        lat = 1 + sh;
`endif
      end
    endcase
  endfunction

  // Issues one operation with out_ready high and checks latency, result and flags.
  task automatic applyStimulus(input int op, input int a, input int b, input string tag);
    int res, car, ovf, lat, cycles;
    model(op, a, b, res, car, ovf, lat);
    @(negedge clk);
    opcode = op[2:0]; A = a[15:0]; B = b[15:0]; in_valid = 1'b1; out_ready = 1'b1;
    checkOutput({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    A = 16'h0; B = 16'h0; opcode = 3'd0;
    if (lat > 1) begin
      checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd1);
      checkOutput({tag, ".in_ready_shift"}, {31'b0, in_ready}, 32'd0);
    end
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    if (!out_valid) begin
      checkOutput({tag, ".timeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, ".latency"}, cycles, lat);
    checkOutput({tag, ".result"}, {16'b0, result}, res);
    checkOutput({tag, ".carryout"}, {31'b0, carryout}, car);
    checkOutput({tag, ".overflow"}, {31'b0, overflow}, ovf);
    checkOutput({tag, ".zero"}, {31'b0, zero}, (res == 0) ? 1 : 0);
  endtask

  initial begin
    int op, a, b, cycles;
    int pick[5] = '{0, 65535, 32768, 32767, 1};
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = 16'h0; B = 16'h0; opcode = 3'd0;
    #12;
    checkOutput("rst.out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst.result", {16'b0, result}, 32'd0);
    checkOutput("rst.busy", {31'b0, busy}, 32'd0);
    checkOutput("rst.flags", {29'b0, carryout, overflow, zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 checkOutput("rst.in_ready", {31'b0, in_ready}, 32'd1);

    applyStimulus(0, 16'hFFFF, 16'h0001, "add_wrap");
    applyStimulus(1, 16'h7FFF, 16'h0001, "sadd_ovf");
    applyStimulus(3, 16'h8000, 16'h0001, "ssub_ovf");
    applyStimulus(2, 16'h0003, 16'h0005, "sub_borrow");
    applyStimulus(2, 16'h0005, 16'h0005, "sub_zero");
    applyStimulus(7, 16'h8001, 16'h0005, "shr5");
    applyStimulus(7, 16'hABCD, 16'h0000, "shr0");
    applyStimulus(7, 16'hFFFF, 16'h000F, "shr15");

    // Backpressure: result must hold while out_ready is low, then a new op issues in the drain cycle.
    @(negedge clk);
    out_ready = 1'b0; opcode = 3'd4; A = 16'hF0F0; B = 16'h0FF0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp.valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp.hold_result", {16'b0, result}, 32'h00F0);
      checkOutput("bp.in_ready_low", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    checkOutput("bp.still_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; opcode = 3'd0; A = 16'h0001; B = 16'h0002;
    #1 checkOutput("bp.in_ready_drain", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp.next_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bp.next_result", {16'b0, result}, 32'h0003);
    @(negedge clk);
    checkOutput("bp.idle", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset while a long shift is in flight.
    applyStimulus(5, 16'h1234, 16'h4321, "or_pre");
    @(negedge clk);
    opcode = 3'd7; A = 16'hFFFF; B = 16'h000F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
`ifndef ALU_BARREL_SHIFT_EN
    checkOutput("rst2.busy_before", {31'b0, busy}, 32'd1);
`endif
    #2 reset = 1'b0;
    #1;
    checkOutput("rst2.result", {16'b0, result}, 32'd0);
    checkOutput("rst2.out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst2.busy", {31'b0, busy}, 32'd0);
    checkOutput("rst2.flags", {29'b0, carryout, overflow, zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst2.in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst2.out_valid_rel", {31'b0, out_valid}, 32'd0);
    applyStimulus(0, 16'h1111, 16'h2222, "after_rst");

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 7);
      a  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : int'($urandom_range(0, 65535));
      b  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : int'($urandom_range(0, 65535));
      applyStimulus(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
    end

    cycles = 0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
